// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchroniser, debouncer, press/release strobes and auto-repeat
module button_conditioner #(
   parameter int N_BTN            = 5,
   parameter int DEBOUNCE_CYC     = 1_000_000,
   parameter int REPEAT_DELAY_CYC = 50_000_000,
   parameter int REPEAT_RATE_CYC  = 10_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic             any_press
);
   localparam int DW   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int RMAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
   localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

   localparam logic [DW-1:0] D_TERM    = DW'(DEBOUNCE_CYC - 1);
   localparam logic [RW-1:0] DLY_TERM  = RW'(REPEAT_DELAY_CYC - 1);
   localparam logic [RW-1:0] RATE_TERM = RW'(REPEAT_RATE_CYC - 1);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

   logic [N_BTN-1:0] r_s1;
   logic [N_BTN-1:0] r_s2;
   logic [N_BTN-1:0] w_press_nxt;
   logic             r_any_press;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1        <= '0;
         r_s2        <= '0;
         r_any_press <= 1'b0;
      end else begin
         r_s1        <= btn_raw;
         r_s2        <= r_s1;
         r_any_press <= |w_press_nxt;
      end
   end

   assign any_press = r_any_press;

   genvar g;
   for (g = 0; g < N_BTN; g++) begin : g_ch
      logic [DW-1:0] r_dcnt;
      logic [RW-1:0] r_rcnt;
      state_t        r_state;
      logic          r_level;
      logic          r_press;
      logic          r_release;
      logic          w_accept;
      logic          w_rise;
      logic          w_fall;
      logic          w_rep;

      assign w_accept = (r_s2[g] != r_level) && (r_dcnt == D_TERM);
      assign w_rise   = w_accept && r_s2[g];
      assign w_fall   = w_accept && !r_s2[g];

      // Outside IDLE the level is high, so any acceptance is a fall and must suppress a repeat.
      always_comb begin
         w_rep = 1'b0;
         if (!w_fall && repeat_en[g]) begin
            if (r_state == DELAY && r_rcnt == DLY_TERM)
               w_rep = 1'b1;
            else if (r_state == REPEAT && r_rcnt == RATE_TERM)
               w_rep = 1'b1;
         end
      end

      assign w_press_nxt[g] = w_rise || w_rep;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_dcnt    <= '0;
            r_rcnt    <= '0;
            r_state   <= IDLE;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= w_press_nxt[g];
            r_release <= w_fall;

            if (r_s2[g] == r_level) begin
               r_dcnt <= '0;
            end else if (r_dcnt == D_TERM) begin
               r_level <= r_s2[g];
               r_dcnt  <= '0;
            end else begin
               r_dcnt <= r_dcnt + DW'(1);
            end

            case (r_state)
               IDLE: begin
                  r_rcnt <= '0;
                  if (w_rise)
                     r_state <= DELAY;
               end
               DELAY: begin
                  if (w_fall) begin
                     r_state <= IDLE;
                     r_rcnt  <= '0;
                  end else if (!repeat_en[g]) begin
                     r_rcnt <= '0;
                  end else if (r_rcnt == DLY_TERM) begin
                     r_state <= REPEAT;
                     r_rcnt  <= '0;
                  end else begin
                     r_rcnt <= r_rcnt + RW'(1);
                  end
               end
               REPEAT: begin
                  if (w_fall) begin
                     r_state <= IDLE;
                     r_rcnt  <= '0;
                  end else if (!repeat_en[g] || r_rcnt == RATE_TERM) begin
                     r_rcnt <= '0;
                  end else begin
                     r_rcnt <= r_rcnt + RW'(1);
                  end
               end
               default: begin
                  r_state <= IDLE;
                  r_rcnt  <= '0;
               end
            endcase
         end
      end

      assign btn_level[g]   = r_level;
      assign btn_press[g]   = r_press;
      assign btn_release[g] = r_release;
   end
endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench for button_conditioner with DEBOUNCE=4, DELAY=10, RATE=3
module tb_button_conditioner;
   logic       clk;
   logic       rst_n;
   logic [4:0] btn_raw;
   logic [4:0] repeat_en;
   logic [4:0] btn_level;
   logic [4:0] btn_press;
   logic [4:0] btn_release;
   logic       any_press;

   int n_checks = 0;
   int n_err    = 0;

   button_conditioner #(
      .N_BTN           (5),
      .DEBOUNCE_CYC    (4),
      .REPEAT_DELAY_CYC(10),
      .REPEAT_RATE_CYC (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .repeat_en  (repeat_en),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .any_press  (any_press)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input logic [4:0] e_lvl, input logic [4:0] e_prs,
                      input logic [4:0] e_rel, input logic e_any, input string tag);
      n_checks++;
      assert (btn_level === e_lvl) else begin
         n_err++;
         $error("FAIL %s btn_level got %b exp %b", tag, btn_level, e_lvl);
      end
      n_checks++;
      assert (btn_press === e_prs) else begin
         n_err++;
         $error("FAIL %s btn_press got %b exp %b", tag, btn_press, e_prs);
      end
      n_checks++;
      assert (btn_release === e_rel) else begin
         n_err++;
         $error("FAIL %s btn_release got %b exp %b", tag, btn_release, e_rel);
      end
      n_checks++;
      assert (any_press === e_any) else begin
         n_err++;
         $error("FAIL %s any_press got %b exp %b", tag, any_press, e_any);
      end
   endtask

   task automatic hold(input int n, input logic [4:0] lvl, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(lvl, 5'b0, 5'b0, 1'b0, tag);
      end
   endtask

   initial begin
      logic e;
      rst_n     = 1'b0;
      btn_raw   = 5'b0;
      repeat_en = 5'b0;
      tick();
      chk(5'b0, 5'b0, 5'b0, 1'b0, "reset_state");
      tick();
      rst_n = 1'b1;
      hold(3, 5'b0, "idle");

      // Clean press/release on C with repeat disabled: the delay expiry must not strobe.
      btn_raw[0] = 1'b1;
      hold(5, 5'b0, "s1_wait");
      tick();
      chk(5'b00001, 5'b00001, 5'b0, 1'b1, "s1_press");
      hold(14, 5'b00001, "s1_hold");
      btn_raw[0] = 1'b0;
      hold(5, 5'b00001, "s1_rel_wait");
      tick();
      chk(5'b0, 5'b0, 5'b00001, 1'b0, "s1_release");
      hold(2, 5'b0, "s1_after");

      // Bounce on U: 3 high, 1 low, 2 high, 1 low, then steady.
      btn_raw[1] = 1'b1; hold(3, 5'b0, "s2_bounce");
      btn_raw[1] = 1'b0; hold(1, 5'b0, "s2_bounce");
      btn_raw[1] = 1'b1; hold(2, 5'b0, "s2_bounce");
      btn_raw[1] = 1'b0; hold(1, 5'b0, "s2_bounce");
      btn_raw[1] = 1'b1;
      hold(5, 5'b0, "s2_wait");
      tick();
      chk(5'b00010, 5'b00010, 5'b0, 1'b1, "s2_press");
      hold(3, 5'b00010, "s2_single");
      btn_raw[1] = 1'b0;
      hold(5, 5'b00010, "s2_rel_wait");
      tick();
      chk(5'b0, 5'b0, 5'b00010, 1'b0, "s2_release");
      hold(2, 5'b0, "s2_after");

      // Auto-repeat on R; level falls at +40 where a repeat would otherwise land.
      repeat_en[3] = 1'b1;
      btn_raw[3]   = 1'b1;
      hold(5, 5'b0, "s3_wait");
      tick();
      chk(5'b01000, 5'b01000, 5'b0, 1'b1, "s3_press");
      for (int k = 1; k <= 39; k++) begin
         tick();
         e = (k >= 10) && ((k - 10) % 3 == 0);
         chk(5'b01000, e ? 5'b01000 : 5'b0, 5'b0, e, $sformatf("s3_rep_k%0d", k));
         if (k == 34) btn_raw[3] = 1'b0;
      end
      tick();
      chk(5'b0, 5'b0, 5'b01000, 1'b0, "s3_release");
      hold(2, 5'b0, "s3_after");

      // Repeat disabled from +14 to +19 while in the rate phase; rate interval restarts at +20.
      btn_raw[3] = 1'b1;
      hold(5, 5'b0, "s4_wait");
      tick();
      chk(5'b01000, 5'b01000, 5'b0, 1'b1, "s4_press");
      for (int k = 1; k <= 31; k++) begin
         tick();
         e = (k inside {10, 13, 22, 25, 28, 31});
         chk(5'b01000, e ? 5'b01000 : 5'b0, 5'b0, e, $sformatf("s4_rep_k%0d", k));
         if (k == 13) repeat_en[3] = 1'b0;
         if (k == 19) repeat_en[3] = 1'b1;
         if (k == 26) btn_raw[3] = 1'b0;
      end
      tick();
      chk(5'b0, 5'b0, 5'b01000, 1'b0, "s4_release");
      hold(2, 5'b0, "s4_after");

      // L and D together.
      btn_raw = 5'b10100;
      hold(5, 5'b0, "s5_wait");
      tick();
      chk(5'b10100, 5'b10100, 5'b0, 1'b1, "s5_press");
      hold(3, 5'b10100, "s5_hold");
      btn_raw = 5'b0;
      hold(5, 5'b10100, "s5_rel_wait");
      tick();
      chk(5'b0, 5'b0, 5'b10100, 1'b0, "s5_release");
      hold(2, 5'b0, "s5_after");

      // Reset in the middle of a repeat strobe with R still held.
      btn_raw[3] = 1'b1;
      hold(5, 5'b0, "s6_wait");
      tick();
      chk(5'b01000, 5'b01000, 5'b0, 1'b1, "s6_press");
      for (int k = 1; k <= 13; k++) begin
         tick();
         e = (k == 10) || (k == 13);
         chk(5'b01000, e ? 5'b01000 : 5'b0, 5'b0, e, $sformatf("s6_rep_k%0d", k));
      end
      #2;
      rst_n = 1'b0;
      #1;
      chk(5'b0, 5'b0, 5'b0, 1'b0, "s6_reset_async");
      tick();
      chk(5'b0, 5'b0, 5'b0, 1'b0, "s6_in_reset");
      tick();
      rst_n = 1'b1;
      hold(5, 5'b0, "s6_post_wait");
      tick();
      chk(5'b01000, 5'b01000, 5'b0, 1'b1, "s6_post_press");
      btn_raw[3] = 1'b0;
      hold(5, 5'b01000, "s6_rel_wait");
      tick();
      chk(5'b0, 5'b0, 5'b01000, 1'b0, "s6_release");
      hold(2, 5'b0, "s6_after");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
